// File: rtl/aritmetica_secuenciador.sv
// rtl/aritmetica_secuenciador.sv - operand sequencer and result collector for the Aritmetica datapath
module aritmetica_secuenciador #(
    parameter int N     = 25,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_const,
    input  logic [N-1:0] in_mult,
    input  logic [N-1:0] in_entr,
    output logic [N-1:0] ar_const,
    output logic [N-1:0] ar_mult,
    output logic [N-1:0] ar_entr,
    input  logic [N-1:0] ar_valores,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy,
    output logic [15:0]  res_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FIFO_FULL = (AW+1)'(DEPTH);
    localparam logic [3:0]  LAT_M1    = 4'(LAT - 1);

    typedef enum logic {
        IDLE,
        SETTLE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     settle_cnt;
    logic [N-1:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    fifo_count;
    logic           accept;
    logic           push;
    logic           pop;

    // Next state and handshake; a FIFO slot is reserved at accept time so the later push always fits
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = (fifo_count < FIFO_FULL);
                accept   = in_valid && in_ready;
                if (accept) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign busy      = (state == SETTLE);

    // State register, settle countdown and the held operand drive to Aritmetica
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            ar_const   <= '0;
            ar_mult    <= '0;
            ar_entr    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                settle_cnt <= LAT_M1;
                ar_const   <= in_const;
                ar_mult    <= in_mult;
                ar_entr    <= in_entr;
            end else if (state == SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
        end
    end

    // FIFO pointers, occupancy and the free-running result counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            res_count  <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                res_count <= res_count + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Result storage; contents are only visible through out_data when the slot is occupied
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ar_valores;
        end
    end

endmodule
